// File: rtl/arb_mux_pkg.sv
// Shared types for the arbitrated output mux.
// Selects between the round-robin search and the fixed-channel path.
package arb_mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FORCE = 1'b1
    } mode_e;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational grant picker: round-robin from last+1, or a single forced channel.
// Zero latency; grants nothing when en_i is low or the forced channel is out of range.
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SELW-1:0]     last_i,
    input  logic                en_i,
    input  mode_e               mode_i,
    input  logic [SELW-1:0]     force_sel_i,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [SELW-1:0]     gnt_idx_o,
    output logic                gnt_vld_o
);

    logic [SELW-1:0] cand_idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand_idx  = '0;
        if (en_i) begin
            if (mode_i == MODE_FORCE) begin
                // A force_sel beyond the last channel matches nothing, so no grant.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (force_sel_i == i[SELW-1:0] && req_i[i]) begin
                        gnt_vld_o = 1'b1;
                        gnt_idx_o = i[SELW-1:0];
                    end
                end
            end else begin
                for (int off = 1; off <= CHANNELS; off++) begin
                    cand_idx = SELW'((int'(last_i) + off) % CHANNELS);
                    if (!gnt_vld_o && req_i[cand_idx]) begin
                        gnt_vld_o = 1'b1;
                        gnt_idx_o = cand_idx;
                    end
                end
            end
        end
        if (gnt_vld_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel W-bit registered mux with round-robin or forced selection.
// One cycle input-to-output latency; inputs stall only while the held word is not taken.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel
);

    localparam logic [SELW-1:0] LAST_RST = SELW'(CHANNELS - 1);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_sel_q,   out_sel_d;
    logic [SELW-1:0]     last_q,      last_d;

    logic                load;
    mode_e               mode;
    logic [CHANNELS-1:0] gnt;
    logic [SELW-1:0]     gnt_idx;
    logic                gnt_vld;
    logic [WIDTH-1:0]    gnt_data;

    assign load = !out_valid_q || out_ready;
    assign mode = force_en ? MODE_FORCE : MODE_RR;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_pick (
        .req_i       (in_valid),
        .last_i      (last_q),
        .en_i        (load),
        .mode_i      (mode),
        .force_sel_i (force_sel),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_vld_o   (gnt_vld)
    );

    // One-hot AND-OR select keeps in_data off the ready path.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt[i]) begin
                gnt_data = gnt_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (gnt_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_sel_d   = gnt_idx;
            if (mode == MODE_RR) begin
                last_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= LAST_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign in_ready  = gnt;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
